// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: multi-cycle data memory for a simple core.
// Each aligned load or store holds the core with Stall for LATENCY+1 cycles,
// then takes one DONE cycle with Stall low. An unaligned request raises
// MisAlign, does not stall, and leaves the RAM alone.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous reset, active low
//   MemWrite   store request (wins if MemRead is also high)
//   MemRead    load request
//   Adr        byte address; word index is Adr[log2(DEPTH)+1:2], upper bits wrap
//   WriteData  store data
//   ReadData   load result; valid in DONE, held until the next load completes
//   Stall      hold PC / suppress RegWrite
//   MisAlign   unaligned request seen in IDLE
//
// state | meaning
// IDLE  | waiting for a request; an aligned request is captured here
// WAIT  | counting down wait cycles; the RAM access happens on the exit edge
// DONE  | one-cycle completion; requests are ignored here
module data_mem_ctrl #(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic [31:0] Adr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        MisAlign
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [3:0]    r_cnt, w_cnt_nxt;
   logic [IW-1:0] r_idx;
   logic [31:0]   r_wdata;
   logic          r_is_wr;
   logic [31:0]   r_mem [DEPTH];

   logic          w_req, w_aligned, w_start, w_commit;
   logic          w_unused;

   assign w_req     = MemWrite | MemRead;
   assign w_aligned = (Adr[1:0] == 2'b00);
   // Address bits above the word index are discarded: accesses wrap modulo DEPTH.
   assign w_unused  = ^Adr[31:IW+2];

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_start     = 1'b0;
      w_commit    = 1'b0;
      Stall       = 1'b0;
      MisAlign    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_req) begin
               if (w_aligned) begin
                  w_start     = 1'b1;
                  Stall       = 1'b1;
                  w_cnt_nxt   = 4'(LATENCY - 1);
                  w_state_nxt = WAIT;
               end else begin
                  MisAlign = 1'b1;
               end
            end
         end
         WAIT: begin
            Stall = 1'b1;
            if (r_cnt == 4'd0) begin
               w_commit    = 1'b1;
               w_state_nxt = DONE;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         DONE: w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
      // Outputs are quiet for the whole time reset is held, whatever the inputs do.
      if (!reset) begin
         Stall    = 1'b0;
         MisAlign = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_cnt    <= 4'd0;
         r_idx    <= '0;
         r_wdata  <= 32'h0;
         r_is_wr  <= 1'b0;
         ReadData <= 32'h0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_start) begin
            r_idx   <= Adr[IW+1:2];
            r_wdata <= WriteData;
            r_is_wr <= MemWrite;
         end
         if (w_commit && !r_is_wr) begin
            ReadData <= r_mem[r_idx];
         end
      end
   end

   // RAM is not reset. A reset during WAIT moves the FSM to IDLE, so the
   // pending commit never fires.
   always_ff @(posedge clk) begin
      if (w_commit && r_is_wr) begin
         r_mem[r_idx] <= r_wdata;
      end
   end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl (DEPTH=64, LATENCY=2).
// The stimulus pushes the expected completion of each access into a queue;
// a monitor on the falling clock edge detects each DONE cycle (Stall falling
// after a stall run) and pops and checks it.
module tb_data_mem_ctrl;

   localparam int DEPTH   = 64;
   localparam int LATENCY = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemWrite, MemRead;
   logic [31:0] Adr, WriteData;
   logic [31:0] ReadData;
   logic        Stall, MisAlign;

   typedef struct {
      bit          is_read;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          n_checks = 0;
   int          n_err    = 0;
   int          stall_cnt = 0;
   logic [31:0] exp_rd = 32'h0;
   logic [7:0]  pat;

   data_mem_ctrl #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
      .clk       (clk),
      .reset     (reset),
      .MemWrite  (MemWrite),
      .MemRead   (MemRead),
      .Adr       (Adr),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .Stall     (Stall),
      .MisAlign  (MisAlign)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 back in IDLE.
   // Inputs are scrambled during WAIT/DONE to show they are ignored.
   task automatic access(input bit we, input bit re, input logic [31:0] adr,
                         input logic [31:0] wd, input bit exp_read, input logic [31:0] exp_data);
      sb.push_back('{exp_read, exp_data});
      MemWrite  = we;
      MemRead   = re;
      Adr       = adr;
      WriteData = wd;
      @(posedge clk); #1;
      MemWrite  = 1'b0;
      MemRead   = 1'b0;
      Adr       = $urandom;
      WriteData = $urandom;
      repeat (LATENCY + 1) @(posedge clk);
      #1;
   endtask

   // Monitor: a falling Stall marks DONE; the stall run length and ReadData are checked there.
   always @(negedge clk) begin
      if (reset) begin
         if (Stall) begin
            stall_cnt++;
            check("rd_hold_during_stall", ReadData, exp_rd);
         end else if (stall_cnt != 0) begin
            if (sb.size() == 0) begin
               check("sb_unexpected_done", 32'(stall_cnt), 32'h0);
            end else begin
               mon_e = sb.pop_front();
               check("stall_len", 32'(stall_cnt), 32'(LATENCY + 1));
               if (mon_e.is_read) exp_rd = mon_e.data;
               check("done_readdata", ReadData, exp_rd);
            end
            stall_cnt = 0;
         end
      end
   end

   always @(negedge reset) begin
      stall_cnt = 0;
      exp_rd    = 32'h0;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not end in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset     = 1'b0;
      MemWrite  = 1'b1;
      MemRead   = 1'b0;
      Adr       = 32'h10;
      WriteData = 32'h0;
      #3;
      check("rst_stall", {31'h0, Stall}, 32'h0);
      check("rst_readdata", ReadData, 32'h0);
      Adr = 32'h12;
      #1;
      check("rst_misalign", {31'h0, MisAlign}, 32'h0);
      MemWrite = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;

      // store/load at 0x10
      access(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
      access(1'b0, 1'b1, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF);

      // 0x100 wraps to word 0
      access(1'b1, 1'b0, 32'h100, 32'h1, 1'b0, 32'h0);
      access(1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 32'h1);

      // unaligned load: flagged, no stall, nothing changes
      MemRead = 1'b1;
      Adr     = 32'h12;
      #1;
      check("mis_flag", {31'h0, MisAlign}, 32'h1);
      check("mis_stall", {31'h0, Stall}, 32'h0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("mis_stay_stall", {31'h0, Stall}, 32'h0);
         check("mis_stay_flag", {31'h0, MisAlign}, 32'h1);
         check("mis_readdata", ReadData, 32'h1);
      end
      @(posedge clk); #1;
      MemRead = 1'b0;
      #1;
      check("mis_clear", {31'h0, MisAlign}, 32'h0);

      // both requests high acts as a write
      access(1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 1'b0, 32'h0);
      access(1'b0, 1'b1, 32'h20, 32'h0, 1'b1, 32'hA5A5A5A5);

      // MemRead held for two back-to-back loads
      @(posedge clk); #1;
      sb.push_back('{1'b1, 32'hDEADBEEF});
      sb.push_back('{1'b1, 32'hA5A5A5A5});
      MemRead = 1'b1;
      Adr     = 32'h10;
      pat     = 8'h0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         pat[7-i] = Stall;
         if (i == 3) begin
            #1 Adr = 32'h20;
         end
      end
      @(posedge clk); #1;
      MemRead = 1'b0;
      check("b2b_stall_pattern", {24'h0, pat}, {24'h0, 8'b1110_1110});

      // reset in first WAIT aborts the second store
      @(posedge clk); #1;
      access(1'b1, 1'b0, 32'h8, 32'h5555, 1'b0, 32'h0);
      MemWrite  = 1'b1;
      Adr       = 32'h8;
      WriteData = 32'hFFFF;
      @(posedge clk); #1;
      MemWrite = 1'b0;
      #1 reset = 1'b0;
      #1;
      check("abort_stall_in_reset", {31'h0, Stall}, 32'h0);
      #1 reset = 1'b1;
      #2;
      check("abort_stall_after", {31'h0, Stall}, 32'h0);
      check("abort_readdata", ReadData, 32'h0);
      @(posedge clk); #1;
      access(1'b0, 1'b1, 32'h8, 32'h0, 1'b1, 32'h5555);

      @(posedge clk); #1;
      check("sb_drained", 32'(sb.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
